// File: rtl/cluster_issue_sched.sv
// Round-robin issue scheduler: N_REQ requesters share one fixed-latency datapath.
// Responses carry the owner id and return in grant order LAT+2 cycles after the handshake.
module cluster_issue_sched #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int LAT   = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     dp_valid,
  output logic [WIDTH-1:0]         dp_data,
  input  logic [WIDTH-1:0]         dp_result,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic [1:0]               state
);

  localparam int IDW  = $clog2(N_REQ);
  localparam int IDW1 = IDW + 1;
  localparam int CW   = $clog2(LAT + 3);
  localparam logic [CW-1:0] CNT_MAX = CW'(LAT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LAT:0]     tag_v_q;
  logic [IDW-1:0]   tag_id_q [0:LAT];
  logic             dp_valid_q;
  logic [WIDTH-1:0] dp_data_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic [IDW1-1:0]  cand_s;
  logic             win_found_s;
  logic [IDW-1:0]   win_id_s;
  logic             grant_s;
  logic [N_REQ-1:0] req_ready_s;
  logic             busy_s;
  logic [WIDTH-1:0] sel_data_s;

  // Rotating priority search starting at ptr_q; first valid requester wins.
  always_comb begin
    win_found_s = 1'b0;
    win_id_s    = {IDW{1'b0}};
    cand_s      = {IDW1{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = {1'b0, ptr_q} + IDW1'(i);
      if (cand_s >= IDW1'(N_REQ)) begin
        cand_s = cand_s - IDW1'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req_valid[cand_s[IDW-1:0]]) begin
        win_found_s = 1'b1;
        win_id_s    = cand_s[IDW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign sel_data_s = req_data[win_id_s*WIDTH +: WIDTH];

  // FSM state register plus round-robin pointer and in-flight counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= {IDW{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next-state: DRAIN only falls back to IDLE once every response is out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
        else        state_d = IDLE;
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
        else         state_d = RUN;
      end
      DRAIN: begin
        if (enable)                    state_d = RUN;
        else if (cnt_q == {CW{1'b0}})  state_d = IDLE;
        else                           state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: one-hot grant, busy flag.
  always_comb begin
    req_ready_s = {N_REQ{1'b0}};
    grant_s     = rst_n && (state_q == RUN) && enable && win_found_s;
    if (grant_s) begin
      req_ready_s[win_id_s] = 1'b1;
    end else begin
      req_ready_s = {N_REQ{1'b0}};
    end
    busy_s = (state_q != IDLE) || (cnt_q != {CW{1'b0}});
  end

  // Pointer advance past the winner, and in-flight bookkeeping.
  always_comb begin
    if (grant_s) begin
      if (win_id_s == IDW'(N_REQ - 1)) ptr_d = {IDW{1'b0}};
      else                             ptr_d = win_id_s + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
    cnt_d = cnt_q;
    case ({grant_s, rsp_valid_q})
      2'b10: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        else                  cnt_d = cnt_q;
      end
      2'b01: begin
        if (cnt_q != {CW{1'b0}}) cnt_d = cnt_q - CW'(1);
        else                     cnt_d = cnt_q;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Issue register, tag pipeline (stage k is live LAT-k cycles before the result) and response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_valid_q  <= 1'b0;
      dp_data_q   <= {WIDTH{1'b0}};
      tag_v_q     <= {(LAT+1){1'b0}};
      for (int k = 0; k <= LAT; k++) tag_id_q[k] <= {IDW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_data_q  <= {WIDTH{1'b0}};
    end else begin
      dp_valid_q <= grant_s;
      if (grant_s) dp_data_q <= sel_data_s;
      tag_v_q     <= {tag_v_q[LAT-1:0], grant_s};
      tag_id_q[0] <= win_id_s;
      for (int k = 1; k <= LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
      if (tag_v_q[LAT]) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= tag_id_q[LAT];
        rsp_data_q  <= dp_result;
      end else begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign req_ready = req_ready_s;
  assign busy      = busy_s;
  assign state     = state_q;
  assign dp_valid  = dp_valid_q;
  assign dp_data   = dp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cluster_issue_sched.sv
// Scoreboard bench: a cycle-level reference model predicts grants, issues and responses;
// a separate monitor pops expectations whenever the DUT presents dp_valid / rsp_valid.
module tb_cluster_issue_sched;
  localparam int WIDTH = 32;
  localparam int N_REQ = 4;
  localparam int LAT   = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   enable;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   dp_valid;
  logic [WIDTH-1:0]       dp_data;
  logic [WIDTH-1:0]       dp_result;
  logic                   rsp_valid;
  logic [1:0]             rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   busy;
  logic [1:0]             state;

  cluster_issue_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_valid(dp_valid), .dp_data(dp_data), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        dp_q[$];
  exp_t        rsp_q[$];
  int          pend_due[$];
  logic [31:0] res_sched [int];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        fixed_res_en = 1'b0;
  logic [31:0] fixed_res = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  int          m_state = 0;
  int          m_ptr = 0;
  int          m_t, m_outst, m_w, m_c;
  logic [31:0] m_r;
  logic [3:0]  m_rdy;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      m_t = cyc;
      while (pend_due.size() > 0 && pend_due[0] < m_t) void'(pend_due.pop_front());
      m_outst = pend_due.size();
      check("state", 64'(state), 64'(m_state));
      check("busy", 64'(busy), 64'((m_state != 0) || (m_outst > 0)));
      m_w = -1;
      if (rst_n && m_state == 1 && enable) begin
        for (int i = 0; i < N_REQ; i++) begin
          m_c = (m_ptr + i) % N_REQ;
          if (m_w < 0 && req_valid[m_c]) m_w = m_c;
        end
      end
      m_rdy = 4'b0000;
      if (m_w >= 0) m_rdy[m_w] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(m_rdy));
      if (!rst_n) begin
        m_state = 0;
        m_ptr   = 0;
        dp_q.delete();
        rsp_q.delete();
        pend_due.delete();
        res_sched.delete();
      end else begin
        if (m_w >= 0) begin
          m_r = fixed_res_en ? fixed_res : $urandom;
          res_sched[m_t + 1 + LAT] = m_r;
          dp_q.push_back('{due: m_t + 1, id: 2'(m_w), data: req_data[m_w*WIDTH +: WIDTH]});
          rsp_q.push_back('{due: m_t + 2 + LAT, id: 2'(m_w), data: m_r});
          pend_due.push_back(m_t + 2 + LAT);
          m_ptr = (m_w + 1) % N_REQ;
        end
        case (m_state)
          0: if (enable) m_state = 1;
          1: if (!enable) m_state = 2;
          2: if (enable) m_state = 1; else if (m_outst == 0) m_state = 0;
          default: m_state = 0;
        endcase
      end
    end
  end

  // Monitor: compares DUT outputs against queued expectations
  exp_t mon_e;
  initial begin
    @(posedge clk);
    forever begin
      #2;
      if (dp_valid && dp_q.size() > 0) begin
        mon_e = dp_q.pop_front();
        check("dp_cycle", 64'(cyc), 64'(mon_e.due));
        check("dp_data", 64'(dp_data), 64'(mon_e.data));
      end else if (dp_valid) begin
        check("dp_valid_unexpected", 64'(dp_valid), 64'(0));
      end else if (dp_q.size() > 0 && dp_q[0].due <= cyc) begin
        check("dp_valid_missing", 64'(dp_valid), 64'(1));
        void'(dp_q.pop_front());
      end
      if (rsp_valid && rsp_q.size() > 0) begin
        mon_e = rsp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(mon_e.due));
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
      end else if (rsp_valid) begin
        check("rsp_valid_unexpected", 64'(rsp_valid), 64'(0));
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        check("rsp_valid_missing", 64'(rsp_valid), 64'(1));
        void'(rsp_q.pop_front());
      end
      @(posedge clk);
    end
  end

  // Datapath stand-in: scheduled result on its cycle, junk otherwise
  initial begin
    dp_result = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (res_sched.exists(cyc)) begin
        dp_result = res_sched[cyc];
        res_sched.delete(cyc);
      end else begin
        dp_result = $urandom;
      end
    end
  end

  task automatic drive(input logic r, input logic en, input logic [3:0] v);
    @(posedge clk);
    #1;
    rst_n     = r;
    enable    = en;
    req_valid = v;
    for (int i = 0; i < N_REQ; i++) req_data[i*WIDTH +: WIDTH] = $urandom;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'hF;
    req_data  = '0;
    repeat (4) drive(1'b0, 1'b1, 4'hF);
    check("rst_dp_valid", 64'(dp_valid), 64'(0));
    check("rst_dp_data", 64'(dp_data), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));

    // single request from requester 2
    fixed_res_en = 1'b1;
    fixed_res    = 32'h0000ABCD;
    repeat (2) begin
      drive(1'b1, 1'b1, 4'b0100);
      req_data[2*WIDTH +: WIDTH] = 32'h00001234;
    end
    drive(1'b1, 1'b1, 4'b0000);
    fixed_res_en = 1'b0;
    repeat (8) drive(1'b1, 1'b1, 4'b0000);

    // all four continuously from ptr=0
    repeat (2) drive(1'b0, 1'b1, 4'b0000);
    repeat (7) drive(1'b1, 1'b1, 4'hF);
    repeat (8) drive(1'b1, 1'b1, 4'b0000);

    // wrap and skip: ptr->3, lone requester 1, then ptr=2 observed
    drive(1'b1, 1'b1, 4'b0100);
    drive(1'b1, 1'b1, 4'b0010);
    drive(1'b1, 1'b1, 4'hF);
    repeat (8) drive(1'b1, 1'b1, 4'b0000);

    // drain with three in flight
    repeat (3) drive(1'b1, 1'b1, 4'hF);
    repeat (12) drive(1'b1, 1'b0, 4'hF);

    // reset mid-operation
    repeat (3) drive(1'b1, 1'b1, 4'hF);
    repeat (2) drive(1'b0, 1'b0, 4'hF);
    repeat (12) drive(1'b1, 1'b0, 4'b0000);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 100) != 0, ($urandom % 5) != 0, 4'($urandom));
    end
    repeat (15) drive(1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    #1;
    check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
    check("dp_q_empty", 64'(dp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cluster_issue_sched.md
CLUSTER_ISSUE_SCHED -- requirements
Module: cluster_issue_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of requests, datapath operand and result.
REQ-002 SHALL have parameter N_REQ, default 4, legal range 2..8: number of requesters.
REQ-003 SHALL have parameter LAT, default 3, legal range 1..8: fixed latency of the shared datapath, dp_valid cycle to dp_result cycle.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  permits new grants.
- req_valid  in  N_REQ  bit i is the request from requester i.
- req_data  in  N_REQ*WIDTH  requester i operand at [i*WIDTH +: WIDTH].
- req_ready  out  N_REQ  grant to requester i; handshake is valid&ready.
- dp_valid  out  1  operand issued to the shared datapath.
- dp_data  out  WIDTH  issued operand.
- dp_result  in  WIDTH  datapath result, valid exactly LAT cycles after the dp_valid cycle.
- rsp_valid  out  1  response valid.
- rsp_id  out  $clog2(N_REQ)  index of the requester that owns the response.
- rsp_data  out  WIDTH  response result.
- busy  out  1  high when state!=IDLE or in-flight count!=0.
- state  out  2  FSM state: IDLE=0, RUN=1, DRAIN=2.

Function
REQ-005 FSM transitions SHALL be: IDLE->RUN on enable=1; RUN->DRAIN on enable=0; DRAIN->RUN on enable=1; DRAIN->IDLE on enable=0 with in-flight=0; all other cases hold.
REQ-006 A grant SHALL be possible only in a cycle with state=RUN and enable=1; in that cycle the combinational req_ready SHALL be 1 for at most one requester.
REQ-007 The winner SHALL be the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
REQ-008 On a handshake, ptr SHALL update to (winner+1) mod N_REQ; with no handshake, ptr SHALL hold.
REQ-009 A requester MAY drop req_valid without a handshake; the block SHALL NOT lock a grant across cycles.
REQ-010 dp_valid and dp_data SHALL be registered: handshake in cycle T gives dp_valid=1 and dp_data=req_data[winner] in cycle T+1; otherwise dp_valid=0 and dp_data holds its last value.
REQ-011 A LAT+1 deep tag pipeline SHALL carry valid and id from each dp_valid cycle.
REQ-012 dp_result SHALL be sampled in cycle T+1+LAT and registered, giving rsp_valid=1, rsp_id=winner and rsp_data=dp_result in cycle T+2+LAT.
REQ-013 Total latency from handshake to response SHALL be LAT+2 cycles; back-to-back handshakes SHALL give back-to-back responses in grant order.
REQ-014 dp_result SHALL be ignored in cycles with no matching tag.
REQ-015 The in-flight counter, width $clog2(LAT+3), SHALL:
- increment on a handshake;
- decrement when rsp_valid=1;
- hold when both events occur in the same cycle.
- Maximum value is LAT+2; the counter SHALL NOT overflow.
REQ-016 Entering DRAIN SHALL NOT cancel in-flight operations; all outstanding responses SHALL still be delivered.

Reset
REQ-017 While rst_n=0 at a clk edge, the block SHALL set:
- state=IDLE, ptr=0, in-flight=0, all tag-pipeline valids=0;
- dp_valid=0, dp_data=0, rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-018 While rst_n=0, req_ready SHALL be 0 and busy SHALL be 0 from the first clk edge with rst_n=0.
REQ-019 Reset mid-operation SHALL discard all in-flight operations; no rsp_valid SHALL occur for requests granted before reset.

Verification
REQ-020 Bench SHALL cover (LAT=3, N_REQ=4):
- Reset with all req_valid=1, enable=1 -> req_ready=0, dp_valid=0, rsp_valid=0, state=0 throughout reset.
- Single request: enable=1, req_valid=4'b0100, req_data[2]=0x00001234 -> req_ready[2]=1 in the first RUN cycle T; dp_valid=1 with dp_data=0x00001234 at T+1; dp_result=0x0000ABCD at T+4 -> rsp_valid=1, rsp_id=2, rsp_data=0x0000ABCD at T+5.
- All four requesters valid continuously, ptr=0 -> grants in order 0,1,2,3,0,1, one per cycle; responses arrive in the same order, back-to-back.
- Wrap and skip: ptr=3, only req_valid[1]=1 -> grant requester 1; ptr becomes 2.
- Drain: 3 operations in flight, enable->0 -> state=2 next cycle; no req_ready; busy=1 until the last rsp_valid; then state=0 and busy=0.
- Reset mid-operation with 2 in flight, then rst_n=1 with enable=0 -> no rsp_valid ever appears; busy=0.
